// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - run-control sequencer generating the fetch-enable strobe
module fetch_sequencer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h0000006F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step_mode,
    input  logic                  step_req,
    input  logic                  halt_req,
    input  logic                  resume,
    input  logic [DATA_WIDTH-1:0] InstrF,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    output logic                  FetchEn,
    output logic                  Running,
    output logic                  Halted,
    output logic [CNT_WIDTH-1:0]  InstrCount,
    output logic [DATA_WIDTH-1:0] HaltPC
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;
    logic   step_pending;
    logic   pending_nxt;
    logic   step_req_q;
    logic   cnt_clr;
    logic   capture;
    logic   acc;
    logic   step_edge;
    logic   halt_det;
    logic   cnt_sat;

    assign FetchEn   = (state == RUN) || ((state == STEP_WAIT) && step_pending);
    assign Running   = (state == RUN) || (state == STEP_WAIT);
    assign Halted    = (state == HALT);
    assign acc       = FetchEn && !StallF;
    assign step_edge = step_req && !step_req_q;
    // A redirect squashes the F-stage instruction, so it must not trigger a halt.
    assign halt_det  = acc && !PCSrcE && (InstrF == HALT_INSTR);
    assign cnt_sat   = (InstrCount == {CNT_WIDTH{1'b1}});

    always_comb begin
        state_nxt   = state;
        pending_nxt = step_pending;
        cnt_clr     = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = step_mode ? STEP_WAIT : RUN;
                    pending_nxt = 1'b0;
                    cnt_clr     = 1'b1;
                end
            end
            RUN, STEP_WAIT: begin
                if (halt_req || halt_det) begin
                    state_nxt   = HALT;
                    pending_nxt = 1'b0;
                    capture     = 1'b1;
                end else if (state == RUN) begin
                    if (step_mode) begin
                        state_nxt   = STEP_WAIT;
                        pending_nxt = 1'b0;
                    end
                end else if (step_mode) begin
                    // A new edge wins over the accept, so back-to-back steps are not lost.
                    pending_nxt = step_edge || (step_pending && !acc);
                end else begin
                    state_nxt   = RUN;
                    pending_nxt = 1'b0;
                end
            end
            HALT: begin
                if (resume) begin
                    state_nxt   = step_mode ? STEP_WAIT : RUN;
                    pending_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            step_pending <= 1'b0;
            step_req_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            step_pending <= pending_nxt;
            step_req_q   <= step_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            InstrCount <= '0;
        end else if (cnt_clr) begin
            InstrCount <= '0;
        end else if (acc && !cnt_sat) begin
            InstrCount <= InstrCount + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            HaltPC <= '0;
        end else if (capture) begin
            HaltPC <= PCF;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step_mode;
    logic        step_req;
    logic        halt_req;
    logic        resume;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        StallF;
    logic        PCSrcE;
    logic        FetchEn;
    logic        Running;
    logic        Halted;
    logic [15:0] InstrCount;
    logic [31:0] HaltPC;
    logic        sat_FetchEn;
    logic        sat_Running;
    logic        sat_Halted;
    logic [3:0]  sat_InstrCount;
    logic [31:0] sat_HaltPC;

    int checks   = 0;
    int failures = 0;
    int fe_cnt;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] HALT = 32'h0000006F;

    always #5 clk = ~clk;

    fetch_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
        .step_req(step_req), .halt_req(halt_req), .resume(resume),
        .InstrF(InstrF), .PCF(PCF), .StallF(StallF), .PCSrcE(PCSrcE),
        .FetchEn(FetchEn), .Running(Running), .Halted(Halted),
        .InstrCount(InstrCount), .HaltPC(HaltPC)
    );

    fetch_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
        .step_req(step_req), .halt_req(halt_req), .resume(resume),
        .InstrF(InstrF), .PCF(PCF), .StallF(StallF), .PCSrcE(PCSrcE),
        .FetchEn(sat_FetchEn), .Running(sat_Running), .Halted(sat_Halted),
        .InstrCount(sat_InstrCount), .HaltPC(sat_HaltPC)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0; start = 0; step_mode = 0; step_req = 0; halt_req = 0; resume = 0;
        InstrF = NOP; PCF = 32'h0; StallF = 0; PCSrcE = 0;

        // 1: reset and free-run
        step_clk(); step_clk();
        check("rst_fetchen", {31'd0, FetchEn}, 32'd0);
        check("rst_running", {31'd0, Running}, 32'd0);
        check("rst_halted",  {31'd0, Halted},  32'd0);
        check("rst_count",   {16'd0, InstrCount}, 32'd0);
        check("rst_haltpc",  HaltPC, 32'd0);
        rst = 1;
        step_clk();
        check("idle_fetchen", {31'd0, FetchEn}, 32'd0);
        start = 1;
        #1 check("start_cycle_fetchen", {31'd0, FetchEn}, 32'd0);
        step_clk();
        start = 0;
        check("run_fetchen", {31'd0, FetchEn}, 32'd1);
        check("run_count0",  {16'd0, InstrCount}, 32'd0);
        for (int i = 0; i < 10; i++) step_clk();
        check("run_count10", {16'd0, InstrCount}, 32'd10);
        check("run_running", {31'd0, Running}, 32'd1);

        // 2: stall holds count
        StallF = 1;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check("stall_fetchen", {31'd0, FetchEn}, 32'd1);
        end
        check("stall_count", {16'd0, InstrCount}, 32'd10);
        StallF = 0;
        step_clk(); step_clk();
        check("post_stall_count", {16'd0, InstrCount}, 32'd12);

        // 3: halt instruction guarded by PCSrcE
        InstrF = HALT; PCF = 32'h40; PCSrcE = 1;
        #1 check("redirect_fetchen", {31'd0, FetchEn}, 32'd1);
        step_clk();
        check("redirect_no_halt", {31'd0, Halted}, 32'd0);
        check("redirect_count", {16'd0, InstrCount}, 32'd13);
        PCSrcE = 0;
        step_clk();
        InstrF = NOP;
        check("halt_halted",  {31'd0, Halted}, 32'd1);
        check("halt_running", {31'd0, Running}, 32'd0);
        check("halt_fetchen", {31'd0, FetchEn}, 32'd0);
        check("halt_pc",      HaltPC, 32'h40);
        check("halt_count",   {16'd0, InstrCount}, 32'd14);
        start = 1;
        step_clk(); step_clk();
        start = 0;
        check("halt_ignores_start", {31'd0, Halted}, 32'd1);
        check("halt_hold_count", {16'd0, InstrCount}, 32'd14);
        resume = 1;
        step_clk();
        resume = 0;
        check("resume_running", {31'd0, Running}, 32'd1);
        check("resume_halted",  {31'd0, Halted}, 32'd0);
        check("resume_fetchen", {31'd0, FetchEn}, 32'd1);
        check("resume_count",   {16'd0, InstrCount}, 32'd14);

        // 4: single-step
        rst = 0;
        step_clk();
        rst = 1; step_mode = 1; start = 1;
        step_clk();
        start = 0;
        check("step_running", {31'd0, Running}, 32'd1);
        check("step_idle_fetchen", {31'd0, FetchEn}, 32'd0);
        check("step_count0", {16'd0, InstrCount}, 32'd0);
        step_req = 1;
        fe_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            if (FetchEn) fe_cnt++;
        end
        step_req = 0;
        step_clk();
        check("step_held_fe_cycles", fe_cnt, 32'd1);
        check("step_held_count", {16'd0, InstrCount}, 32'd1);
        step_req = 1; StallF = 1;
        step_clk();
        step_req = 0;
        fe_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            StallF = (i < 2);
            #1 if (FetchEn) fe_cnt++;
            step_clk();
        end
        check("step_stall_fe_cycles", fe_cnt, 32'd3);
        check("step_stall_count", {16'd0, InstrCount}, 32'd2);
        step_req = 1;
        step_clk();
        step_req = 0; StallF = 1;
        step_clk();
        step_req = 1; StallF = 0;
        step_clk();
        step_req = 0;
        check("step_edge_acc_pending", {31'd0, FetchEn}, 32'd1);
        step_clk();
        check("step_edge_acc_done", {31'd0, FetchEn}, 32'd0);
        check("step_edge_acc_count", {16'd0, InstrCount}, 32'd4);

        // 5: simultaneous halt sources, then mid-run reset
        step_mode = 0;
        step_clk();
        check("step_to_run", {31'd0, FetchEn}, 32'd1);
        check("step_to_run_count", {16'd0, InstrCount}, 32'd4);
        halt_req = 1; InstrF = HALT; PCF = 32'h80;
        step_clk();
        halt_req = 0; InstrF = NOP;
        check("both_halt_halted", {31'd0, Halted}, 32'd1);
        check("both_halt_pc", HaltPC, 32'h80);
        check("both_halt_count", {16'd0, InstrCount}, 32'd5);
        resume = 1;
        step_clk();
        resume = 0; step_mode = 1;
        step_clk();
        check("run_to_step_count", {16'd0, InstrCount}, 32'd6);
        check("run_to_step_fetchen", {31'd0, FetchEn}, 32'd0);
        step_req = 1;
        step_clk();
        check("pending_before_rst", {31'd0, FetchEn}, 32'd1);
        rst = 0; step_req = 0;
        step_clk();
        check("midrst_fetchen", {31'd0, FetchEn}, 32'd0);
        check("midrst_running", {31'd0, Running}, 32'd0);
        check("midrst_count", {16'd0, InstrCount}, 32'd0);
        check("midrst_haltpc", HaltPC, 32'd0);
        rst = 1; start = 1;
        step_clk();
        start = 0;
        check("midrst_pending_dropped", {31'd0, FetchEn}, 32'd0);

        // 6: saturation on the narrow-counter instance
        rst = 0;
        step_clk();
        rst = 1; step_mode = 0; start = 1;
        step_clk();
        start = 0;
        for (int i = 0; i < 16; i++) step_clk();
        check("sat_boundary_wide", {16'd0, InstrCount}, 32'd16);
        check("sat_boundary_narrow", {28'd0, sat_InstrCount}, 32'd15);
        for (int i = 0; i < 4; i++) step_clk();
        check("sat_wide_20", {16'd0, InstrCount}, 32'd20);
        check("sat_narrow_hold", {28'd0, sat_InstrCount}, 32'd15);
        check("sat_running", {31'd0, sat_Running}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
